seven_seg_capture: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment display driver.
- Watches the active-low segment/anode bus, waits for each scan slot to settle, and decodes the segment pattern back to a BCD digit per anode position.
- Reports one pulse per full four-digit frame, plus per-digit blank and invalid-pattern flags and a scan-stall flag.
- Used as an on-chip self-check and as the bench's display monitor for stopwatch MM:SS readback.

---
 rtl/seven_seg_capture.sv | 211 +++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: decodes a multiplexed active-low 7-segment bus
// back into per-anode BCD digits with frame, blank, error and stall flags.
//
// Ports:
//   clk_100mhz   system clock
//   rst_n        async active-low reset
//   segment      active-low segments {g,f,e,d,c,b,a}
//   anode        active-low digit enables, [3] = MM tens, [0] = SS ones
//   digit3..0    last decoded BCD value per anode slot (F on bad pattern)
//   digit_blank  slot i last seen with all segments off
//   digit_err    slot i last seen with an undecodable pattern
//   frame_valid  one-cycle pulse once all four slots are captured
//   scan_stalled no capture for TIMEOUT_CYCLES cycles
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 400000
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic [6:0] segment,
  input  logic [3:0] anode,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] digit_blank,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       scan_stalled
);

  localparam logic [7:0]  STAB_MAX =
    8'(STABLE_CYCLES);
  localparam logic [7:0]  STAB_PRE =
    8'(STABLE_CYCLES - 1);
  localparam logic [19:0] TMO_MAX  =
    20'(TIMEOUT_CYCLES);
  localparam logic [19:0] TMO_PRE  =
    20'(TIMEOUT_CYCLES - 1);

  localparam logic [10:0] S_IDLE = {4'hF, 7'h7F};

  logic [10:0] s_q;
  logic [10:0] s_prev;
  logic [7:0]  stab_cnt;
  logic [19:0] tmo_cnt;
  logic [3:0]  seen;
  logic [3:0]  dig_q [4];
  logic [3:0]  blank_q;
  logic [3:0]  err_q;
  logic        fv_q;
  logic        stall_q;

  logic        same;
  logic [3:0]  slot_oh;
  logic        capture;
  logic        tmo_hit;
  logic [3:0]  seen_nxt;
  logic [3:0]  dec_val;
  logic        dec_ok;
  logic        dec_blank;

  // Input stage: one register, plus a copy for change detection.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= S_IDLE;
      s_prev <= S_IDLE;
    end else begin
      s_q    <= {anode, segment};
      s_prev <= s_q;
    end
  end

  assign same = (s_q == s_prev);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
    end else if (!same) begin
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // Exactly one anode low selects a slot; anything else is ignored.
  always_comb begin
    slot_oh = 4'b0000;
    case (s_q[10:7])
      4'b1110: slot_oh = 4'b0001;
      4'b1101: slot_oh = 4'b0010;
      4'b1011: slot_oh = 4'b0100;
      4'b0111: slot_oh = 4'b1000;
      default: slot_oh = 4'b0000;
    endcase
  end

  // Fires once per stable period, on the final step to saturation.
  assign capture = same
                && (stab_cnt == STAB_PRE)
                && (|slot_oh);

  always_comb begin
    dec_val   = 4'hF;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (s_q[6:0])
      7'h40: dec_val = 4'd0;
      7'h79: dec_val = 4'd1;
      7'h24: dec_val = 4'd2;
      7'h30: dec_val = 4'd3;
      7'h19: dec_val = 4'd4;
      7'h12: dec_val = 4'd5;
      7'h02: dec_val = 4'd6;
      7'h78: dec_val = 4'd7;
      7'h00: dec_val = 4'd8;
      7'h10: dec_val = 4'd9;
      7'h7F: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_ok  = 1'b0;
        dec_val = 4'hF;
      end
    endcase
  end

  // Per-slot digit and flag registers.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= 4'd0;
      end
      blank_q <= '0;
      err_q   <= '0;
    end else if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (slot_oh[i]) begin
          if (dec_ok) begin
            dig_q[i]   <= dec_val;
            blank_q[i] <= 1'b0;
            err_q[i]   <= 1'b0;
          end else if (dec_blank) begin
            // Hold digit so blinking keeps its value.
            blank_q[i] <= 1'b1;
            err_q[i]   <= 1'b0;
          end else begin
            dig_q[i]   <= 4'hF;
            blank_q[i] <= 1'b0;
            err_q[i]   <= 1'b1;
          end
        end
      end
    end
  end

  assign seen_nxt = seen | slot_oh;

  // Stall check only matters when no capture lands this edge.
  assign tmo_hit = !capture && (tmo_cnt == TMO_PRE);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (capture) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else if (capture) begin
      stall_q <= 1'b0;
    end else if (tmo_hit) begin
      stall_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
      fv_q <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      if (capture) begin
        if (seen_nxt == 4'hF) begin
          seen <= '0;
          fv_q <= 1'b1;
        end else begin
          seen <= seen_nxt;
        end
      end else if (tmo_hit) begin
        seen <= '0;
      end
    end
  end

  assign digit3       = dig_q[3];
  assign digit2       = dig_q[2];
  assign digit1       = dig_q[1];
  assign digit0       = dig_q[0];
  assign digit_blank  = blank_q;
  assign digit_err    = err_q;
  assign frame_valid  = fv_q;
  assign scan_stalled = stall_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed bench for seven_seg_capture
// with STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_seven_seg_capture;

  logic       clk_100mhz = 1'b0;
  logic       rst_n      = 1'b0;
  logic [6:0] segment    = 7'h7F;
  logic [3:0] anode      = 4'hF;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [3:0] digit_blank, digit_err;
  logic       frame_valid, scan_stalled;

  int n_cmp  = 0;
  int n_bad  = 0;
  int fv_cnt = 0;
  int fv_base;

  seven_seg_capture #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .segment     (segment),
    .anode       (anode),
    .digit3      (digit3),
    .digit2      (digit2),
    .digit1      (digit1),
    .digit0      (digit0),
    .digit_blank (digit_blank),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .scan_stalled(scan_stalled)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(negedge clk_100mhz) begin
    if (frame_valid) fv_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // Drive a pattern, then wait n edges; returns #1 after the last.
  task automatic show(input logic [3:0] a,
                      input logic [6:0] s,
                      input int n);
    anode   = a;
    segment = s;
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  function automatic logic [15:0] digs();
    return {digit3, digit2, digit1, digit0};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk_100mhz);
    #1;
    chk("rst_digits", 32'(digs()), 32'h0);
    chk("rst_flags",
        {22'd0, digit_blank, digit_err,
         frame_valid, scan_stalled}, 32'h0);
    rst_n = 1'b1;

    // Latency: update on the 6th edge.
    show(4'hE, 7'h24, 5);
    chk("lat_edge5", 32'(digit0), 32'h0);
    show(4'hE, 7'h24, 1);
    chk("lat_edge6", 32'(digit0), 32'h2);
    chk("lat_no_fv", 32'(frame_valid), 32'h0);
    show(4'hE, 7'h24, 4);

    // Reset so the scan starts with an empty frame.
    rst_n = 1'b0;
    #1;
    chk("rst2_digit0", 32'(digit0), 32'h0);
    @(posedge clk_100mhz);
    #1;
    rst_n = 1'b1;

    fv_base = fv_cnt;
    show(4'h7, 7'h40, 8);
    show(4'hB, 7'h19, 8);
    show(4'hD, 7'h30, 8);
    chk("scan_fv_early", 32'(fv_cnt - fv_base), 32'h0);
    show(4'hE, 7'h10, 5);
    chk("scan_fv_pre", 32'(frame_valid), 32'h0);
    show(4'hE, 7'h10, 1);
    chk("scan_fv_hit", 32'(frame_valid), 32'h1);
    chk("scan_d0_hit", 32'(digit0), 32'h9);
    show(4'hE, 7'h10, 2);
    chk("scan_fv_post", 32'(frame_valid), 32'h0);
    chk("scan_digits", 32'(digs()), 32'h0439);
    chk("scan_fv_once", 32'(fv_cnt - fv_base), 32'h1);

    // Blank holds the digit value.
    show(4'hD, 7'h30, 8);
    show(4'hD, 7'h7F, 8);
    chk("blank_set", 32'(digit_blank), 32'h2);
    chk("blank_hold", 32'(digit1), 32'h3);
    show(4'hD, 7'h30, 8);
    chk("blank_clr", 32'(digit_blank), 32'h0);

    // Bad pattern sets err and digit F.
    show(4'hB, 7'h7E, 8);
    chk("err_digit", 32'(digit2), 32'hF);
    chk("err_set", 32'(digit_err), 32'h4);
    show(4'hB, 7'h12, 8);
    chk("err_fix", 32'(digit2), 32'h5);
    chk("err_clr", 32'(digit_err), 32'h0);

    // Glitches and multi-anode must not capture.
    fv_base = fv_cnt;
    show(4'hE, 7'h40, 2);
    show(4'hE, 7'h79, 2);
    show(4'hC, 7'h00, 10);
    chk("glitch_digits", 32'(digs()), 32'h0539);
    chk("glitch_flags",
        32'({digit_blank, digit_err}), 32'h0);
    // seen is {2,1}; slots 3 and 0 close the frame.
    show(4'h7, 7'h02, 8);
    chk("glitch_fv_mid", 32'(fv_cnt - fv_base), 32'h0);
    show(4'hE, 7'h79, 5);
    chk("glitch_fv_pre", 32'(frame_valid), 32'h0);
    show(4'hE, 7'h79, 1);
    chk("glitch_fv_hit", 32'(frame_valid), 32'h1);
    chk("glitch_digs2", 32'(digs()), 32'h6531);
    show(4'hE, 7'h79, 2);

    // Partial frame, then stall clears seen.
    fv_base = fv_cnt;
    show(4'h7, 7'h40, 8);
    show(4'hB, 7'h40, 8);
    show(4'hD, 7'h40, 8);
    show(4'hF, 7'h7F, 61);
    chk("stall_pre", 32'(scan_stalled), 32'h0);
    show(4'hF, 7'h7F, 1);
    chk("stall_set", 32'(scan_stalled), 32'h1);
    show(4'hF, 7'h7F, 8);
    chk("stall_hold", 32'(scan_stalled), 32'h1);
    show(4'hE, 7'h24, 5);
    chk("stall_pre_cap", 32'(scan_stalled), 32'h1);
    show(4'hE, 7'h24, 1);
    chk("stall_clr", 32'(scan_stalled), 32'h0);
    chk("stall_no_fv", 32'(fv_cnt - fv_base), 32'h0);
    chk("stall_digits", 32'(digs()), 32'h0002);
    show(4'hE, 7'h24, 2);

    // Reset mid-frame discards seen.
    show(4'h7, 7'h19, 8);
    chk("mid_d3", 32'(digit3), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", 32'(digs()), 32'h0);
    chk("mid_rst_flags",
        {22'd0, digit_blank, digit_err,
         frame_valid, scan_stalled}, 32'h0);
    @(posedge clk_100mhz);
    #1;
    rst_n = 1'b1;
    fv_base = fv_cnt;
    show(4'hB, 7'h30, 8);
    show(4'hD, 7'h30, 8);
    show(4'h7, 7'h79, 8);
    chk("mid_no_fv", 32'(fv_cnt - fv_base), 32'h0);
    show(4'hE, 7'h00, 8);
    chk("mid_fv", 32'(fv_cnt - fv_base), 32'h1);
    chk("mid_digits", 32'(digs()), 32'h1338);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
